if_prefetch_stage: RTL and testbench
====================================

IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries, power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port freeze, input, 1: suppress new fetch requests.
REQ-007 SHALL have port Branch_taken, input, 1: redirect and flush.
REQ-008 SHALL have port BranchAddr, input, XLEN: redirect target.
REQ-009 SHALL have port imem_req, output, 1: read request this cycle.
REQ-010 SHALL have port imem_addr, output, XLEN: read address, word aligned.
REQ-011 SHALL have port imem_rdata, input, XLEN: read data, valid exactly one cycle after imem_req.
REQ-012 SHALL have port id_valid, output, 1: queue head available.
REQ-013 SHALL have port id_ready, input, 1: decode accepts head.
REQ-014 SHALL have port id_instr, output, XLEN: head instruction.
REQ-015 SHALL have port id_pc, output, XLEN: head instruction address.
REQ-016 SHALL have port id_pc_plus4, output, XLEN: id_pc+4 modulo 2^XLEN.

Function
REQ-017 SHALL hold fetch_pc register; imem_addr = fetch_pc with bits [1:0] forced 0.
REQ-018 SHALL assert imem_req iff !freeze, !Branch_taken, and (queue count + in-flight) < DEPTH.
REQ-019 SHALL advance fetch_pc by 4 on each issued request, wrapping modulo 2^XLEN.
REQ-020 SHALL allow at most one request in flight; response captured the cycle after issue and pushed with its address.
REQ-021 SHALL assert id_valid iff queue not empty and Branch_taken low; pop on id_valid && id_ready.
REQ-022 SHALL support simultaneous push and pop, including when full; count unchanged.
REQ-023 On Branch_taken: fetch_pc <= {BranchAddr[XLEN-1:2],2'b00}; queue emptied next cycle; pending response discarded via epoch bit toggle.
REQ-024 Branch_taken SHALL take priority over freeze and over any push/pop in the same cycle.
REQ-025 Under freeze: fetch_pc held, in-flight response still pushed, queue still drains.
REQ-026 First request SHALL issue the first cycle after reset release, address RESET_PC.

Reset
REQ-027 rst low SHALL asynchronously set fetch_pc=RESET_PC, queue empty, in-flight=0, epoch=0, counters=0.
REQ-028 During reset: imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4.
REQ-029 Reset asserted mid-flight SHALL drop the outstanding response; no push after release.

Configuration
REQ-030 With IF_PREFETCH_PERF_CNT_EN defined: outputs perf_fetched (32, pops) and perf_flushes (32, Branch_taken cycles), wrapping counters.
REQ-031 Without IF_PREFETCH_PERF_CNT_EN: those ports and counters absent; other behaviour identical.

Structure
REQ-032 Package if_pkg SHALL hold XLEN default, PC_STEP=4 and the queue entry typedef {pc, instr}.
REQ-033 Queue SHALL be sub-module if_prefetch_fifo (DEPTH, entry width, sync flush); all else in top.

Verification
REQ-034 Reset release, id_ready=1, memory returns addr^32'hA5A5_0000: id_pc sequence 0,4,8,... with matching instr, one per cycle after 2-cycle fill latency.
REQ-035 id_ready=0 for 10 cycles: exactly DEPTH pushes, imem_req drops, no overflow; resume delivers 0..4*(DEPTH-1) in order.
REQ-036 Branch_taken with BranchAddr=32'h103 while request in flight: stale response dropped, next id_pc=32'h100.
REQ-037 freeze=1 for 5 cycles with Branch_taken pulse at cycle 3: no request during freeze; first request after freeze at branch target.
REQ-038 fetch_pc=32'hFFFF_FFFC: next request address 0, id_pc_plus4 of head = 0.
REQ-039 With IF_PREFETCH_PERF_CNT_EN: 7 pops and 2 flushes give perf_fetched=7, perf_flushes=2; rst low mid-sequence zeros both.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared constants and types for the instruction prefetch stage.
//               XLEN_DEFAULT : default address / instruction width
//               PC_STEP      : byte distance between sequential instructions
//               if_entry_t   : prefetch queue entry {pc, instr}
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_STEP      = 4;

  // Entry layout at the default width; the stage re-declares the same
  // layout at its own XLEN so the queue can be built for any width.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_fifo
// Description : Power-of-two circular queue holding fetched {pc, instr}
//               entries. Combinational head read, synchronous flush,
//               simultaneous push/pop allowed even when full.
// Ports       : clk, rst (async active-low), flush (sync clear),
//               push/wr_data, pop/rd_data (head), empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop frees the head slot in the same cycle, so a full queue can still
  // accept a push when it is also being popped. Flush overrides both.
  assign w_pop  = pop && !empty && !flush;
  assign w_push = push && (!w_full || w_pop) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the stage masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_stage
// Description : Instruction fetch prefetcher. Issues sequential word-aligned
//               reads (one outstanding, data returned next cycle), queues
//               {pc, instr} and hands the head to decode. Branch_taken
//               redirects, flushes the queue and drops any pending response.
// Ports       : clk, rst (async active-low), freeze, Branch_taken, BranchAddr,
//               imem_req/imem_addr/imem_rdata, id_valid/id_ready,
//               id_instr/id_pc/id_pc_plus4
// Config      : IF_PREFETCH_PERF_CNT_EN adds perf_fetched (pops) and
//               perf_flushes (Branch_taken cycles) 32-bit wrapping counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            Branch_taken,
  input  logic [XLEN-1:0] BranchAddr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef IF_PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]      r_fetch_pc;
  logic [XLEN-1:0]      r_inflight_pc;
  logic                 r_inflight;
  logic                 r_inflight_epoch;
  logic                 r_epoch;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  entry_t               w_wr_entry;
  entry_t               w_head;
  logic [$bits(entry_t)-1:0] w_rd_data;

  assign imem_addr = r_fetch_pc & ALIGN_MASK;

  // Queue occupancy plus the outstanding slot must stay below DEPTH so a
  // response always has room. rst gating keeps the request low in reset.
  assign imem_req = rst && !freeze && !Branch_taken &&
                    ((int'(w_count) + int'(r_inflight)) < DEPTH);

  // A response is kept only if no redirect happened since it was issued.
  assign w_push = r_inflight && (r_inflight_epoch == r_epoch) && !Branch_taken;
  assign w_pop  = id_valid && id_ready;

  assign w_wr_entry.pc    = r_inflight_pc;
  assign w_wr_entry.instr = imem_rdata;

  assign id_valid    = !w_empty && !Branch_taken;
  assign w_head      = w_empty ? '0 : entry_t'(w_rd_data);
  assign id_instr    = w_head.instr;
  assign id_pc       = w_head.pc;
  assign id_pc_plus4 = w_head.pc + STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc       <= RESET_PC;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_inflight_pc    <= imem_addr;
        r_inflight_epoch <= r_epoch;
      end
      if (Branch_taken) begin
        r_fetch_pc <= BranchAddr & ALIGN_MASK;
        r_epoch    <= ~r_epoch;
      end else if (imem_req) begin
        r_fetch_pc <= r_fetch_pc + STEP;
      end
    end
  end

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (Branch_taken),
    .push    (w_push),
    .wr_data (w_wr_entry),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .empty   (w_empty),
    .count   (w_count)
  );

`ifdef IF_PREFETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop)        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (Branch_taken) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_stage
// Description : Self-checking bench for if_prefetch_stage. Directed scenario
//               tasks plus a randomized run against a queue-based reference
//               model of the fetch rules. Memory returns addr ^ 32'hA5A5_0000
//               one cycle after each request.
// Config      : IF_PREFETCH_PERF_CNT_EN enables the performance counter test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] BranchAddr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef IF_PREFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int errors = 0;

  if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .BranchAddr   (BranchAddr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4)
`ifdef IF_PREFETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: sample the request at the edge, present data shortly
  // after so it is stable for the following edge. Garbage when idle.
  initial begin
    logic        pend;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      pend = imem_req;
      a    = imem_addr;
      #1 imem_rdata = pend ? (a ^ KEY) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic set_in(input logic f, input logic b, input logic [31:0] a, input logic r);
    freeze       = f;
    Branch_taken = b;
    BranchAddr   = a;
    id_ready     = r;
  endtask

  // Ends just after a falling edge with rst released: "cycle 0".
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h55, 1'b1);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want 4", id_pc_plus4); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          errors++; $display("FAIL stream_first_req: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
      end
      if (k < 2) begin
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_fill: cycle %0d got valid=%0b want 0", k, id_valid); end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        exp_p4 = exp_pc + 32'd4;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY) || id_pc_plus4 !== exp_p4) begin
          errors++;
          $display("FAIL stream_head: cycle %0d got v=%0b pc=%h in=%h p4=%h want v=1 pc=%h in=%h p4=%h",
                   k, id_valid, id_pc, id_instr, id_pc_plus4, exp_pc, exp_pc ^ KEY, exp_p4);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    logic [31:0] exp_pc;
    do_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (imem_req === 1'b1) nreq++;
      if (k == 9) begin
        checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stalled: got req=%0b valid=%0b want req=0 valid=1", imem_req, id_valid);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nreq != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d want %0d", nreq, DEPTH); end
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      exp_pc = 32'(4 * k);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin
        errors++;
        $display("FAIL bp_drain: entry %0d got v=%0b pc=%h in=%h want v=1 pc=%h in=%h",
                 k, id_valid, id_pc, id_instr, exp_pc, exp_pc ^ KEY);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    do_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL br_pre_req: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h103, 1'b1);
    #1;
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL br_cycle: got req=%0b valid=%0b want 0 0", imem_req, id_valid);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++; $display("FAIL br_target_req: got req=%0b addr=%h valid=%0b want 1 00000100 0", imem_req, imem_addr, id_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL br_stale_drop: got valid=%0b pc=%h want valid=0", id_valid, id_pc); end
    @(negedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== (32'h100 ^ KEY)) begin
      errors++; $display("FAIL br_head: got v=%0b pc=%h in=%h want v=1 pc=00000100 in=%h", id_valid, id_pc, id_instr, 32'h100 ^ KEY);
    end
    @(negedge clk);
  endtask

  task automatic test_freeze();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, (k == 3), 32'h20A, 1'b1);
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL frz_req: cycle %0d got req=%0b want 0", k, imem_req); end
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h208) begin
      errors++; $display("FAIL frz_resume: got req=%0b addr=%h want req=1 addr=00000208", imem_req, imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req0: got req=%0b addr=%h want 1 fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_req1: got req=%0b addr=%h want 1 00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== (32'hFFFF_FFFC ^ KEY)) begin
      errors++; $display("FAIL wrap_head: got v=%0b pc=%h p4=%h in=%h want v=1 pc=fffffffc p4=0 in=%h",
                         id_valid, id_pc, id_pc_plus4, id_instr, 32'hFFFF_FFFC ^ KEY);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    #1;
    @(negedge clk);
    // Response for address 0 is due at the next edge; reset lands first.
    #2 rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got req=%0b valid=%0b want 0 0", imem_req, id_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_restart: got req=%0b addr=%h valid=%0b want 1 0 0", imem_req, imem_addr, id_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_push: got valid=%0b pc=%h want valid=0", id_valid, id_pc); end
    @(negedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      errors++; $display("FAIL mid_rst_head: got v=%0b pc=%h want v=1 pc=0", id_valid, id_pc);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference: queue of delivered-but-not-consumed instructions, the next
  // fetch address, and whether a response is due at the coming edge.
  task automatic test_random();
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_inf_pc;
    int          m_inf;
    logic        f, b, r, e_req, e_valid;
    logic [31:0] a, e_addr, e_p4;
    do_reset();
    m_pc = 32'h0; m_inf = 0; m_inf_pc = 32'h0;
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom);
      r = ($urandom_range(0, 2) != 0);
      set_in(f, b, a, r);
      #1;
      e_req   = !f && !b && ((q.size() + m_inf) < DEPTH);
      e_addr  = m_pc & ~32'h3;
      e_valid = (q.size() > 0) && !b;
      checks++;
      if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req: cycle %0d got %0b want %0b", n, imem_req, e_req); end
      if (e_req) begin
        checks++;
        if (imem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h want %h", n, imem_addr, e_addr); end
      end
      checks++;
      if (id_valid !== e_valid) begin errors++; $display("FAIL rnd_valid: cycle %0d got %0b want %0b", n, id_valid, e_valid); end
      if (e_valid) begin
        e_p4 = q[0].pc + 32'd4;
        checks++;
        if (id_pc !== q[0].pc || id_instr !== q[0].instr || id_pc_plus4 !== e_p4) begin
          errors++;
          $display("FAIL rnd_head: cycle %0d got pc=%h in=%h p4=%h want pc=%h in=%h p4=%h",
                   n, id_pc, id_instr, id_pc_plus4, q[0].pc, q[0].instr, e_p4);
        end
      end
      if (b) begin
        q.delete();
        m_inf = 0;
        m_pc  = a & ~32'h3;
      end else begin
        if (e_valid && r) void'(q.pop_front());
        if (m_inf != 0) q.push_back('{m_inf_pc, m_inf_pc ^ KEY});
        m_inf = e_req ? 1 : 0;
        if (e_req) begin
          m_inf_pc = e_addr;
          m_pc     = m_pc + 32'd4;
        end
      end
      @(negedge clk);
    end
  endtask

`ifdef IF_PREFETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (6) @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (7) @(negedge clk);
    set_in(1'b0, 1'b1, 32'h40, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++;
    if (perf_fetched !== 32'd7 || perf_flushes !== 32'd2) begin
      errors++; $display("FAIL perf_counts: got fetched=%0d flushes=%0d want 7 2", perf_fetched, perf_flushes);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got fetched=%0d flushes=%0d want 0 0", perf_fetched, perf_flushes);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_freeze();
    test_wrap();
    test_reset_midflight();
    test_random();
`ifdef IF_PREFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
